// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin scheduler sharing one 4x4 unsigned multiplier
// among NREQ requesters. Each requester offers operands on a valid/ready
// channel. Products return on one valid/ready channel, tagged with the
// requester index.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  [NREQ]    per-requester operand valid
//   req_x      [4*NREQ]  operand x, requester i at [4i+3:4i]
//   req_y      [4*NREQ]  operand y, requester i at [4i+3:4i]
//   req_ready  [NREQ]    one-hot (or zero) grant
//   res_valid            product valid
//   res_ready            consumer ready
//   res_id     [IDW]     owner of res_prod
//   res_prod   [8]       x*y, unsigned
//   busy                 an operation is in flight
//
// Build option: define MULT_SHARE_PIPE_EN to add an operand stage ahead of the
// multiplier. This gives 2-cycle latency at full throughput.
//
// Output stage states:
//   state | meaning
//   EMPTY | no result held
//   FULL  | result held in output register

module main (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] o
);
  logic [7:0] pp0, pp1, pp2, pp3;
  logic [7:0] s01, s23;

  assign pp0 = y[0] ? {4'b0000, x}        : 8'd0;
  assign pp1 = y[1] ? {3'b000, x, 1'b0}   : 8'd0;
  assign pp2 = y[2] ? {2'b00, x, 2'b00}   : 8'd0;
  assign pp3 = y[3] ? {1'b0, x, 3'b000}   : 8'd0;
  assign s01 = pp0 + pp1;
  assign s23 = pp2 + pp3;
  assign o   = s01 + s23;
endmodule

module mult_share_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_x,
  input  logic [4*NREQ-1:0] req_y,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic [7:0]        res_prod,
  output logic              busy
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic [7:0]     res_prod_q, res_prod_d;

  logic           accept;
  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic           hs;
  logic           out_load;
  logic [IDW-1:0] load_id;
  logic [3:0]     sel_x, sel_y;
  logic [3:0]     mul_x, mul_y;
  logic [7:0]     mul_o;

  assign res_valid = (state_q == FULL);
  assign res_id    = res_id_q;
  assign res_prod  = res_prod_q;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int unsigned j;
    j         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (32'(rr_ptr_q) + 32'(k)) % 32'(NREQ);
      if (!gnt_found && req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = j[IDW-1:0];
      end
    end
  end

  assign hs = accept && gnt_found;

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[gnt_idx] = 1'b1;
  end

  assign sel_x = req_x[{gnt_idx, 2'b00} +: 4];
  assign sel_y = req_y[{gnt_idx, 2'b00} +: 4];

`ifdef MULT_SHARE_PIPE_EN
  logic [3:0]     op_x_q, op_y_q;
  logic [IDW-1:0] op_id_q;
  logic           op_v_q;
  logic           out_adv;

  assign out_adv  = op_v_q && (!res_valid || res_ready);
  // Operand stage accepts when empty or emptying this cycle.
  assign accept   = !rst && (!op_v_q || out_adv);
  assign out_load = out_adv;
  assign mul_x    = op_x_q;
  assign mul_y    = op_y_q;
  assign load_id  = op_id_q;
  assign busy     = op_v_q | res_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_v_q  <= 1'b0;
      op_x_q  <= '0;
      op_y_q  <= '0;
      op_id_q <= '0;
    end else if (hs) begin
      op_v_q  <= 1'b1;
      op_x_q  <= sel_x;
      op_y_q  <= sel_y;
      op_id_q <= gnt_idx;
    end else if (out_adv) begin
      op_v_q  <= 1'b0;
    end
  end
`else
  // Pass-through on a draining result keeps one product per cycle.
  assign accept   = !rst && (!res_valid || res_ready);
  assign out_load = hs;
  assign mul_x    = sel_x;
  assign mul_y    = sel_y;
  assign load_id  = gnt_idx;
  assign busy     = res_valid;
`endif

  main u_mul (
    .x (mul_x),
    .y (mul_y),
    .o (mul_o)
  );

  always_comb begin
    state_d    = state_q;
    res_id_d   = res_id_q;
    res_prod_d = res_prod_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      EMPTY: if (out_load) state_d = FULL;
      FULL:  if (!out_load && res_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (out_load) begin
      res_id_d   = load_id;
      res_prod_d = mul_o;
    end
    if (hs) rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      rr_ptr_q   <= '0;
      res_id_q   <= '0;
      res_prod_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      res_id_q   <= res_id_d;
      res_prod_q <= res_prod_d;
    end
  end

endmodule

// File: tb/tb_mult_share_sched.sv
module tb_mult_share_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_x, req_y;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic [7:0]  res_prod;
  logic        busy;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] prod;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  mult_share_sched #(.NREQ(4), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_prod  (res_prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs are changed #1 after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs, let combinational logic settle, check the grant.
  task automatic offer(input logic [3:0] v, input logic [3:0] exp_rdy, input string name);
    req_valid = v;
    #1;
    chk(name, int'(req_ready), int'(exp_rdy));
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] prod);
    exp_t e;
    e.id   = id;
    e.prod = prod;
    exp_q.push_back(e);
  endtask

  // Monitor: every delivered result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_id", int'(res_id), int'(e.id));
        chk("res_prod", int'(res_prod), int'(e.prod));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_x     = '0;
    req_y     = '0;
    res_ready = 1'b1;

    // Reset for 2 cycles; grant must be suppressed while rst is high.
    cyc();
    req_valid = 4'b1111;
    #1;
    chk("rdy_in_reset", int'(req_ready), 0);
    cyc();
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_res_prod", int'(res_prod), 0);
    chk("rst_res_id", int'(res_id), 0);
    req_valid = 4'b0000;
    rst = 1'b0;

    // Single op: 13*11 = 143 from requester 0, result next cycle.
    req_x = 16'h000D;
    req_y = 16'h000B;
    offer(4'b0001, 4'b0001, "single_grant");
    push(2'd0, 8'd143);
    cyc();
    req_valid = 4'b0000;
    chk("single_latency_valid", int'(res_valid), 1);
    chk("single_busy", int'(busy), 1);
    cyc();
    chk("single_drained", int'(res_valid), 0);

    // Round robin from rr_ptr=0: x_i=i+1, y=15.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req_x = {4'd4, 4'd3, 4'd2, 4'd1};
    req_y = {4'd15, 4'd15, 4'd15, 4'd15};
    offer(4'b1111, 4'b0001, "rr_0");   push(2'd0, 8'd15);  cyc();
    offer(4'b1111, 4'b0010, "rr_1");   push(2'd1, 8'd30);  cyc();
    chk("rr_throughput", int'(res_valid), 1);
    offer(4'b1111, 4'b0100, "rr_2");   push(2'd2, 8'd45);  cyc();
    offer(4'b1111, 4'b1000, "rr_3");   push(2'd3, 8'd60);  cyc();
    offer(4'b1111, 4'b0001, "rr_4");   push(2'd0, 8'd15);  cyc();
    req_valid = 4'b0000;
    cyc();

    // Back-pressure: 9*9 from requester 0 (rr_ptr=1), then stall 5 cycles.
    req_x = {4'd0, 4'd5, 4'd2, 4'd9};
    req_y = {4'd0, 4'd7, 4'd3, 4'd9};
    offer(4'b0001, 4'b0001, "bp_load");
    push(2'd0, 8'd81);
    cyc();
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(4'b0110, 4'b0000, "bp_rdy_blocked");
      chk("bp_valid_held", int'(res_valid), 1);
      chk("bp_prod_held", int'(res_prod), 81);
      chk("bp_id_held", int'(res_id), 0);
      cyc();
    end
    res_ready = 1'b1;
    offer(4'b0110, 4'b0010, "bp_release_grant1");
    push(2'd1, 8'd6);
    cyc();
    offer(4'b0110, 4'b0100, "bp_next_grant2");
    push(2'd2, 8'd35);
    cyc();
    req_valid = 4'b0000;
    cyc();

    // Corners from requester 3 (rr_ptr=3).
    req_x[15:12] = 4'd0;  req_y[15:12] = 4'd15;
    offer(4'b1000, 4'b1000, "corner_0x15");  push(2'd3, 8'd0);   cyc();
    req_x[15:12] = 4'd15; req_y[15:12] = 4'd15;
    offer(4'b1000, 4'b1000, "corner_15x15"); push(2'd3, 8'd225); cyc();
    req_x[15:12] = 4'd1;  req_y[15:12] = 4'd1;
    offer(4'b1000, 4'b1000, "corner_1x1");   push(2'd3, 8'd1);   cyc();
    req_x[15:12] = 4'd8;  req_y[15:12] = 4'd8;
    offer(4'b1000, 4'b1000, "corner_8x8");   push(2'd3, 8'd64);  cyc();
    // Operand changes after handshake must not disturb the held product.
    req_x[15:12] = 4'd2;
    offer(4'b0000, 4'b0000, "corner_idle");
    cyc();

    // Skip idle: drive rr_ptr to 3 via requester 2, then 2 again.
    req_x[11:8] = 4'd7;
    req_y[11:8] = 4'd6;
    offer(4'b0100, 4'b0100, "skip_first");     push(2'd2, 8'd42); cyc();
    offer(4'b0100, 4'b0100, "skip_ptr3_grant"); push(2'd2, 8'd42); cyc();
    offer(4'b0000, 4'b0000, "drop_valid_nogrant");
    cyc();
    req_x[15:12] = 4'd8;
    offer(4'b1111, 4'b1000, "skip_ptr_is_3");  push(2'd3, 8'd64); cyc();
    req_valid = 4'b0000;
    cyc();

    // Reset mid-op: requester 1 result held (rr_ptr=2), then rst.
    req_x[7:4] = 4'd9;
    req_y[7:4] = 4'd9;
    offer(4'b0010, 4'b0010, "midrst_grant");
    cyc();
    req_valid = 4'b0000;
    res_ready = 1'b0;
    chk("midrst_held", int'(res_valid), 1);
    rst = 1'b1;
    cyc();
    chk("midrst_valid", int'(res_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    rst = 1'b0;
    res_ready = 1'b1;
    req_x[3:0] = 4'd3;
    req_y[3:0] = 4'd4;
    offer(4'b1111, 4'b0001, "midrst_ptr0");
    push(2'd0, 8'd12);
    cyc();
    req_valid = 4'b0000;

    // Drain, bounded.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    chk("drain_pending", exp_q.size(), 0);
    cyc();
    chk("final_idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
